instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   Instruction/operand byte fetcher feeding the 6502 decoder. Owns the program counter, issues
//   byte reads to memory, and presents each byte on instruction_out with a one-cycle
//   instruction_ready pulse. Advances only when the decoder asserts get_next. Accepts PC
//   redirects for jumps, branches and interrupts.
// PARAMETERS
//   REG_WIDTH   `REG_WIDTH (8)   data byte width
//   ADDR_WIDTH  `ADDR_WIDTH (16) address / PC width
//   RESET_PC    16'h0200         PC after reset when RESET_VECTOR_EN is undefined
// PORTS
//   clk              in   1           clock, all state on rising edge
//   reset_n          in   1           asynchronous active-low reset
//   data_in          in   REG_WIDTH   memory read data, valid one cycle after addr is driven
//   get_next         in   1           decoder consumed current byte; fetch PC+1
//   load_pc          in   1           redirect PC to new_pc
//   new_pc           in   ADDR_WIDTH  redirect target
//   addr             out  ADDR_WIDTH  memory read address
//   read_write       out  1           1 = read; fetcher never writes
//   instruction_out  out  REG_WIDTH   fetched byte, stable until next instruction_ready
//   instruction_ready out 1           one-cycle pulse: instruction_out newly valid
//   pc               out  ADDR_WIDTH  address of byte on instruction_out
// BEHAVIOUR
//   Reset (async, reset_n=0): pc=RESET_PC, addr=RESET_PC, instruction_out=0,
//     instruction_ready=0, read_write=1, state=REQ (VEC_LO with RESET_VECTOR_EN).
//   FSM states: REQ, WAIT, HOLD (+ VEC_LO, VEC_HI, VEC_WAIT with RESET_VECTOR_EN).
//   REQ:  addr<=pc; -> WAIT.
//   WAIT: memory returns data; instruction_out<=data_in; instruction_ready<=1 (one cycle); -> HOLD.
//   HOLD: instruction_ready=0 after first cycle. get_next=1 -> pc<=pc+1, -> REQ.
//     get_next accepted in the same cycle the ready pulse is high.
//   Latency: get_next sampled at edge N -> addr=pc+1 after edge N+1 -> ready pulse after edge N+2.
//   get_next while in REQ/WAIT: ignored (no PC change, no queued request).
//   load_pc (any non-vector state): pc<=new_pc, in-flight read discarded (no ready pulse), -> REQ.
//     load_pc and get_next same cycle: load_pc wins, no increment.
//     load_pc during VEC_* states: ignored.
//   PC arithmetic: ADDR_WIDTH-bit modulo; 16'hFFFF + 1 = 16'h0000, no flag.
//   read_write is constant 1 out of reset.
//   reset_n asserted mid-fetch: all state to reset values immediately; pending byte lost.
// CONFIGURATION
//   RESET_VECTOR_EN defined: after reset, read 16'hFFFC (low) then 16'hFFFD (high) via
//     VEC_LO -> VEC_WAIT -> VEC_HI -> VEC_WAIT, pc<={hi,lo}, -> REQ. No ready pulses
//     for vector bytes. First opcode pulse 6 cycles after reset release.
//   RESET_VECTOR_EN undefined: pc=RESET_PC, first ready pulse 2 cycles after reset release.
// TESTING
//   1 Reset release, mem[0200]=A9 (macro off) -> addr=0200, ready pulse cycle 2, instruction_out=A9, pc=0200.
//   2 Hold get_next=0 10 cycles -> instruction_out stays A9, exactly one ready pulse; then
//     get_next with mem[0201]=05 -> pulse 2 cycles later, out=05, pc=0201.
//   3 load_pc=1,new_pc=1234 with get_next=1 same cycle -> next byte from 1234, no fetch of pc+1.
//   4 pc=FFFF, get_next -> addr=0000, pc=0000, byte mem[0000] presented.
//   5 load_pc during WAIT -> stale byte never pulsed; next pulse carries mem[new_pc].
//   6 Macro on, mem[FFFC]=00, mem[FFFD]=80 -> first pulse byte mem[8000], pc=8000;
//     reset_n pulsed low mid-fetch -> outputs immediately at reset values, sequence restarts.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction/operand byte fetcher for the 6502 decoder: owns the PC and hands each byte
// over with a one-cycle ready pulse. Define RESET_VECTOR_EN to boot through $FFFC/$FFFD.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module instr_fetch #(
   parameter int unsigned           REG_WIDTH  = `REG_WIDTH,
   parameter int unsigned           ADDR_WIDTH = `ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(16'h0200)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [REG_WIDTH-1:0]  data_in,
   input  logic                  get_next,
   input  logic                  load_pc,
   input  logic [ADDR_WIDTH-1:0] new_pc,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  read_write,
   output logic [REG_WIDTH-1:0]  instruction_out,
   output logic                  instruction_ready,
   output logic [ADDR_WIDTH-1:0] pc
);

   typedef enum logic [2:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_VEC_LO,
      S_VEC_HI,
      S_VEC_WAIT
   } state_t;

`ifdef RESET_VECTOR_EN
   localparam state_t                BOOT_STATE  = S_VEC_LO;
   localparam logic [ADDR_WIDTH-1:0] VEC_LO_ADDR = ADDR_WIDTH'(16'hFFFC);
   localparam logic [ADDR_WIDTH-1:0] VEC_HI_ADDR = ADDR_WIDTH'(16'hFFFD);
`else
   localparam state_t                BOOT_STATE  = S_REQ;
`endif

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [REG_WIDTH-1:0]  instr_q, instr_d;
   logic                  ready_q, ready_d;
`ifdef RESET_VECTOR_EN
   // vec_hi_q tells the shared VEC_WAIT state which vector byte is arriving.
   logic [REG_WIDTH-1:0]  vec_lo_q, vec_lo_d;
   logic                  vec_hi_q, vec_hi_d;
`endif

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= BOOT_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_REQ:  state_d = load_pc ? S_REQ : S_WAIT;
         S_WAIT: state_d = load_pc ? S_REQ : S_HOLD;
         S_HOLD: if (load_pc || get_next) state_d = S_REQ;
`ifdef RESET_VECTOR_EN
         S_VEC_LO:   state_d = S_VEC_WAIT;
         S_VEC_HI:   state_d = S_VEC_WAIT;
         S_VEC_WAIT: state_d = vec_hi_q ? S_REQ : S_VEC_HI;
`endif
         default: state_d = BOOT_STATE;
      endcase
   end

   // get_next is only honoured in HOLD; a redirect drops whatever byte is in flight.
   always_comb begin
      pc_d    = pc_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      ready_d = 1'b0;
`ifdef RESET_VECTOR_EN
      vec_lo_d = vec_lo_q;
      vec_hi_d = vec_hi_q;
`endif
      unique case (state_q)
         S_REQ: begin
            if (load_pc) pc_d = new_pc;
            else         addr_d = pc_q;
         end
         S_WAIT: begin
            if (load_pc) begin
               pc_d = new_pc;
            end else begin
               instr_d = data_in;
               ready_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (load_pc)       pc_d = new_pc;
            else if (get_next) pc_d = pc_q + ADDR_WIDTH'(1);
         end
`ifdef RESET_VECTOR_EN
         S_VEC_LO: begin
            addr_d   = VEC_LO_ADDR;
            vec_hi_d = 1'b0;
         end
         S_VEC_HI: begin
            addr_d   = VEC_HI_ADDR;
            vec_hi_d = 1'b1;
         end
         S_VEC_WAIT: begin
            if (vec_hi_q) pc_d = ADDR_WIDTH'({data_in, vec_lo_q});
            else          vec_lo_d = data_in;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q     <= RESET_PC;
         addr_q   <= RESET_PC;
         instr_q  <= '0;
         ready_q  <= 1'b0;
`ifdef RESET_VECTOR_EN
         vec_lo_q <= '0;
         vec_hi_q <= 1'b0;
`endif
      end else begin
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         instr_q  <= instr_d;
         ready_q  <= ready_d;
`ifdef RESET_VECTOR_EN
         vec_lo_q <= vec_lo_d;
         vec_hi_q <= vec_hi_d;
`endif
      end
   end

   assign pc                = pc_q;
   assign addr              = addr_q;
   assign instruction_out   = instr_q;
   assign instruction_ready = ready_q;
   assign read_write        = 1'b1;

   a_ready_single : assert property (@(posedge clk) disable iff (!reset_n)
      instruction_ready |=> !instruction_ready);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected {pc, byte} pairs are queued as stimulus is
// driven and popped when the ready pulse appears; latency and pulse counts checked inline.
module tb_instr_fetch;

   localparam logic [15:0] RESET_PC = 16'h0200;
`ifdef RESET_VECTOR_EN
   localparam logic [15:0] START_PC = 16'h8000;
   localparam int          BOOT_LAT = 6;
`else
   localparam logic [15:0] START_PC = 16'h0200;
   localparam int          BOOT_LAT = 2;
`endif

   typedef struct packed {
      logic [15:0] pc;
      logic [7:0]  data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  data_in;
   logic        get_next;
   logic        load_pc;
   logic [15:0] new_pc;
   logic [15:0] addr;
   logic        read_write;
   logic [7:0]  instruction_out;
   logic        instruction_ready;
   logic [15:0] pc;

   logic [7:0]  mem [0:65535];
   exp_t        sb_q[$];
   int          n_compared   = 0;
   int          n_mismatched = 0;
   int          pulse_cnt    = 0;

   instr_fetch dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .data_in           (data_in),
      .get_next          (get_next),
      .load_pc           (load_pc),
      .new_pc            (new_pc),
      .addr              (addr),
      .read_write        (read_write),
      .instruction_out   (instruction_out),
      .instruction_ready (instruction_ready),
      .pc                (pc)
   );

   always #5 clk = ~clk;
   assign data_in = mem[addr];
   always @(negedge clk) if (instruction_ready === 1'b1) pulse_cnt++;

   function automatic exp_t mk(input logic [15:0] p, input logic [7:0] d);
      exp_t e;
      e.pc   = p;
      e.data = d;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until a ready pulse is seen; lat = steps taken, or -1 when the budget runs out.
   task automatic await_pulse(input int budget, output int lat);
      lat = -1;
      for (int i = 1; i <= budget; i++) begin
         step();
         if (instruction_ready === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      exp_t e;
      int   lat;
      get_next = 1'b0; load_pc = 1'b0; new_pc = '0;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      n_compared++; if (pc !== RESET_PC) begin n_mismatched++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
      n_compared++; if (addr !== RESET_PC) begin n_mismatched++; $display("FAIL reset_addr: got %h want %h", addr, RESET_PC); end
      n_compared++; if (instruction_ready !== 1'b0) begin n_mismatched++; $display("FAIL reset_ready: got %b want 0", instruction_ready); end
      n_compared++; if (instruction_out !== 8'h00) begin n_mismatched++; $display("FAIL reset_out: got %h want 00", instruction_out); end
      n_compared++; if (read_write !== 1'b1) begin n_mismatched++; $display("FAIL reset_rw: got %b want 1", read_write); end
      step(); step();
      reset_n = 1'b1;
      sb_q.push_back(mk(START_PC, mem[START_PC]));
      await_pulse(20, lat);
      n_compared++; if (lat !== BOOT_LAT) begin n_mismatched++; $display("FAIL boot_latency: got %0d want %0d", lat, BOOT_LAT); end
      e = sb_q.pop_front();
      n_compared++; if (instruction_out !== e.data) begin n_mismatched++; $display("FAIL boot_data: got %h want %h", instruction_out, e.data); end
      n_compared++; if (pc !== e.pc) begin n_mismatched++; $display("FAIL boot_pc: got %h want %h", pc, e.pc); end
   endtask

   task automatic test_hold();
      exp_t e;
      int   lat, base;
      base = pulse_cnt;
      repeat (10) step();
      n_compared++; if (instruction_out !== mem[START_PC]) begin n_mismatched++; $display("FAIL hold_out: got %h want %h", instruction_out, mem[START_PC]); end
      n_compared++; if (pulse_cnt - base !== 1) begin n_mismatched++; $display("FAIL hold_pulses: got %0d want 1", pulse_cnt - base); end
      n_compared++; if (pc !== START_PC) begin n_mismatched++; $display("FAIL hold_pc: got %h want %h", pc, START_PC); end
      sb_q.push_back(mk(START_PC + 16'd1, 8'h05));
      get_next = 1'b1; step(); get_next = 1'b0;
      n_compared++; if (instruction_ready !== 1'b0) begin n_mismatched++; $display("FAIL next_early_ready: got %b want 0", instruction_ready); end
      await_pulse(10, lat);
      n_compared++; if (lat !== 2) begin n_mismatched++; $display("FAIL next_latency: got %0d want 2", lat); end
      e = sb_q.pop_front();
      n_compared++; if (instruction_out !== e.data) begin n_mismatched++; $display("FAIL next_data: got %h want %h", instruction_out, e.data); end
      n_compared++; if (pc !== e.pc) begin n_mismatched++; $display("FAIL next_pc: got %h want %h", pc, e.pc); end
   endtask

   // get_next raised in the very cycle the ready pulse is high, three times in a row.
   task automatic test_back_to_back();
      exp_t        e;
      int          lat;
      logic [15:0] p;
      for (int k = 0; k < 3; k++) begin
         p = pc + 16'd1;
         sb_q.push_back(mk(p, mem[p]));
         get_next = 1'b1; step(); get_next = 1'b0;
         await_pulse(10, lat);
         n_compared++; if (lat !== 2) begin n_mismatched++; $display("FAIL b2b_latency[%0d]: got %0d want 2", k, lat); end
         e = sb_q.pop_front();
         n_compared++; if (instruction_out !== e.data) begin n_mismatched++; $display("FAIL b2b_data[%0d]: got %h want %h", k, instruction_out, e.data); end
         n_compared++; if (pc !== e.pc) begin n_mismatched++; $display("FAIL b2b_pc[%0d]: got %h want %h", k, pc, e.pc); end
      end
   endtask

   // get_next held through REQ and WAIT must advance the PC only once.
   task automatic test_ignore();
      exp_t        e;
      int          base;
      logic [15:0] p;
      p = pc + 16'd1;
      sb_q.push_back(mk(p, mem[p]));
      get_next = 1'b1;
      step(); step(); step();
      get_next = 1'b0;
      n_compared++; if (instruction_ready !== 1'b1) begin n_mismatched++; $display("FAIL ignore_ready: got %b want 1", instruction_ready); end
      e = sb_q.pop_front();
      n_compared++; if (instruction_out !== e.data) begin n_mismatched++; $display("FAIL ignore_data: got %h want %h", instruction_out, e.data); end
      base = pulse_cnt;
      repeat (4) step();
      n_compared++; if (pc !== p) begin n_mismatched++; $display("FAIL ignore_pc: got %h want %h", pc, p); end
      n_compared++; if (pulse_cnt - base !== 1) begin n_mismatched++; $display("FAIL ignore_pulses: got %0d want 1", pulse_cnt - base); end
   endtask

   task automatic test_load_priority();
      exp_t e;
      int   lat;
      sb_q.push_back(mk(16'h1234, 8'h3C));
      load_pc = 1'b1; new_pc = 16'h1234; get_next = 1'b1;
      step();
      load_pc = 1'b0; get_next = 1'b0;
      n_compared++; if (pc !== 16'h1234) begin n_mismatched++; $display("FAIL load_pc_value: got %h want 1234", pc); end
      step();
      n_compared++; if (addr !== 16'h1234) begin n_mismatched++; $display("FAIL load_addr: got %h want 1234", addr); end
      await_pulse(10, lat);
      n_compared++; if (lat !== 1) begin n_mismatched++; $display("FAIL load_latency: got %0d want 1", lat); end
      e = sb_q.pop_front();
      n_compared++; if (instruction_out !== e.data) begin n_mismatched++; $display("FAIL load_data: got %h want %h", instruction_out, e.data); end
      n_compared++; if (pc !== e.pc) begin n_mismatched++; $display("FAIL load_pc_out: got %h want %h", pc, e.pc); end
   endtask

   task automatic test_wrap();
      exp_t e;
      int   lat;
      sb_q.push_back(mk(16'hFFFF, mem[16'hFFFF]));
      load_pc = 1'b1; new_pc = 16'hFFFF; step(); load_pc = 1'b0;
      await_pulse(10, lat);
      e = sb_q.pop_front();
      n_compared++; if (pc !== e.pc) begin n_mismatched++; $display("FAIL wrap_pre_pc: got %h want %h (lat %0d)", pc, e.pc, lat); end
      sb_q.push_back(mk(16'h0000, 8'hEA));
      get_next = 1'b1; step(); get_next = 1'b0;
      n_compared++; if (pc !== 16'h0000) begin n_mismatched++; $display("FAIL wrap_pc: got %h want 0000", pc); end
      step();
      n_compared++; if (addr !== 16'h0000) begin n_mismatched++; $display("FAIL wrap_addr: got %h want 0000", addr); end
      await_pulse(10, lat);
      n_compared++; if (lat !== 1) begin n_mismatched++; $display("FAIL wrap_latency: got %0d want 1", lat); end
      e = sb_q.pop_front();
      n_compared++; if (instruction_out !== e.data) begin n_mismatched++; $display("FAIL wrap_data: got %h want %h", instruction_out, e.data); end
   endtask

   // Redirect while the read of pc+1 is in flight: that byte must never be presented.
   task automatic test_load_in_wait();
      exp_t e;
      int   lat, base;
      step();
      base = pulse_cnt;
      sb_q.push_back(mk(16'h3000, 8'h77));
      get_next = 1'b1; step(); get_next = 1'b0;
      step();
      n_compared++; if (addr !== 16'h0001) begin n_mismatched++; $display("FAIL lw_addr: got %h want 0001", addr); end
      load_pc = 1'b1; new_pc = 16'h3000; step(); load_pc = 1'b0;
      n_compared++; if (instruction_ready !== 1'b0) begin n_mismatched++; $display("FAIL lw_stale_ready: got %b want 0", instruction_ready); end
      n_compared++; if (instruction_out !== 8'hEA) begin n_mismatched++; $display("FAIL lw_stale_out: got %h want ea", instruction_out); end
      await_pulse(10, lat);
      n_compared++; if (lat !== 2) begin n_mismatched++; $display("FAIL lw_latency: got %0d want 2", lat); end
      e = sb_q.pop_front();
      n_compared++; if (instruction_out !== e.data) begin n_mismatched++; $display("FAIL lw_data: got %h want %h", instruction_out, e.data); end
      n_compared++; if (pc !== e.pc) begin n_mismatched++; $display("FAIL lw_pc: got %h want %h", pc, e.pc); end
      n_compared++; if (pulse_cnt - base !== 0) begin n_mismatched++; $display("FAIL lw_pulses: got %0d want 0", pulse_cnt - base); end
   endtask

   task automatic test_reset_mid_fetch();
      exp_t e;
      int   lat;
      get_next = 1'b1; step(); get_next = 1'b0;
      step();
      #1 reset_n = 1'b0;
      #1;
      sb_q.delete();
      n_compared++; if (pc !== RESET_PC) begin n_mismatched++; $display("FAIL mid_reset_pc: got %h want %h", pc, RESET_PC); end
      n_compared++; if (addr !== RESET_PC) begin n_mismatched++; $display("FAIL mid_reset_addr: got %h want %h", addr, RESET_PC); end
      n_compared++; if (instruction_out !== 8'h00) begin n_mismatched++; $display("FAIL mid_reset_out: got %h want 00", instruction_out); end
      step(); step();
      n_compared++; if (instruction_ready !== 1'b0) begin n_mismatched++; $display("FAIL mid_reset_ready: got %b want 0", instruction_ready); end
      reset_n = 1'b1;
      sb_q.push_back(mk(START_PC, mem[START_PC]));
      await_pulse(20, lat);
      n_compared++; if (lat !== BOOT_LAT) begin n_mismatched++; $display("FAIL reboot_latency: got %0d want %0d", lat, BOOT_LAT); end
      e = sb_q.pop_front();
      n_compared++; if (instruction_out !== e.data) begin n_mismatched++; $display("FAIL reboot_data: got %h want %h", instruction_out, e.data); end
      n_compared++; if (pc !== e.pc) begin n_mismatched++; $display("FAIL reboot_pc: got %h want %h", pc, e.pc); end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = a[7:0] ^ a[15:8] ^ 8'h5A;
      mem[START_PC]         = 8'hA9;
      mem[START_PC + 16'd1] = 8'h05;
      mem[16'h0000]         = 8'hEA;
      mem[16'h0001]         = 8'h11;
      mem[16'h1234]         = 8'h3C;
      mem[16'h3000]         = 8'h77;
`ifdef RESET_VECTOR_EN
      mem[16'hFFFC]         = 8'h00;
      mem[16'hFFFD]         = 8'h80;
`endif
      test_reset();
      test_hold();
      test_back_to_back();
      test_ignore();
      test_load_priority();
      test_wrap();
      test_load_in_wait();
      test_reset_mid_fetch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
